// File: rtl/pio_poll_pkg.sv
// Shared constants and types for the PIO poll scheduler.
package pio_poll_pkg;

    // CSR word addresses
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    // CTRL bit indices
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_OVF_CLR = 2;

    // STATUS bit positions
    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 8;

    // EVENT word field positions; the FIFO stores bits [23:0] only
    localparam int unsigned EVT_VALID   = 31;
    localparam int unsigned EVT_PORT_LSB = 16;
    localparam int unsigned EVT_OLD_LSB  = 8;
    localparam int unsigned EVT_NEW_LSB  = 0;
    localparam int unsigned EVT_W        = 24;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StWait,
        StCmp,
        StNext
    } scan_state_e;

endpackage

// File: rtl/pio_poll_fifo.sv
// Synchronous event FIFO; push and pop in the same cycle are both honoured, even when full.
module pio_poll_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Head as it stands this cycle; a same-cycle push never bypasses to here
    assign pop_data = mem_q[rptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pio_poll_scheduler.sv
// Round-robin PIO sampler that queues per-port change events for the Nios II.
module pio_poll_scheduler
    import pio_poll_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned PORT_W     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned POLL_DIV   = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [1:0]                mst_address,
    output logic [NUM_PORTS-1:0]      mst_select,
    input  logic [NUM_PORTS*32-1:0]   mst_readdata,
    input  logic [1:0]                s_address,
    input  logic                      s_read,
    input  logic                      s_write,
    input  logic [31:0]               s_writedata,
    output logic [31:0]               s_readdata,
    output logic                      irq
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DIV_W = $clog2(POLL_DIV);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q;
    logic [NUM_PORTS-1:0] mask_q, mask_d, primed_q, primed_d;
    logic [PORT_W-1:0]    shadow_q [NUM_PORTS];
    logic [PORT_W-1:0]    shadow_d [NUM_PORTS];
    logic [PORT_W-1:0]    lanes [NUM_PORTS];
    logic [31:0]          rdata_q, rdata_d;
    logic                 tick, pop, push_req;
    logic [EVT_W-1:0]     push_data, fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full, fifo_empty;

    assign mst_address = 2'b00;
    assign s_readdata  = rdata_q;
    assign irq         = irq_q;
    assign tick        = en_q && (div_q == DIV_W'(POLL_DIV - 1));
    assign pop         = s_read && (s_address == ADDR_EVENT) && !fifo_empty;

    pio_poll_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Split the concatenated readdata bus into per-port valid lanes
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            lanes[p] = mst_readdata[32*p +: PORT_W];
        end
    end

    // CSR decode, control registers, overflow flag and scan divider
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        mask_d   = mask_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        if (s_write && s_address == ADDR_CTRL) begin
            en_d     = s_writedata[CTRL_ENABLE];
            irq_en_d = s_writedata[CTRL_IRQ_EN];
            if (s_writedata[CTRL_OVF_CLR]) begin
                ovf_d = 1'b0;
            end
        end
        if (s_write && s_address == ADDR_MASK) begin
            mask_d = s_writedata[NUM_PORTS-1:0];
        end
        // A fresh drop outranks a same-cycle clear so it is never lost
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (s_read) begin
            rdata_d = '0;
            unique case (s_address)
                ADDR_STATUS: begin
                    rdata_d[STAT_EMPTY]                 = fifo_empty;
                    rdata_d[STAT_FULL]                  = fifo_full;
                    rdata_d[STAT_OVF]                   = ovf_q;
                    rdata_d[STAT_CNT_LSB +: 4]          = 4'(fifo_count);
                end
                ADDR_EVENT: begin
                    if (!fifo_empty) begin
                        rdata_d[EVT_VALID]  = 1'b1;
                        rdata_d[EVT_W-1:0]  = fifo_head;
                    end
                end
                ADDR_CTRL: begin
                    rdata_d[CTRL_ENABLE] = en_q;
                    rdata_d[CTRL_IRQ_EN] = irq_en_q;
                end
                ADDR_MASK: rdata_d = 32'(mask_q);
            endcase
        end
        div_d = '0;
        if (en_q && en_d) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Scan FSM: next state, port index, shadow/primed update and event push
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        primed_d   = primed_q & mask_q;
        push_req   = 1'b0;
        push_data  = '0;
        mst_select = '0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StSel;
                    idx_d   = '0;
                end
            end
            StSel: state_d = mask_q[idx_q] ? StWait : StNext;
            StWait: begin
                mst_select[idx_q] = 1'b1;
                state_d           = StCmp;
            end
            StCmp: begin
                mst_select[idx_q] = 1'b1;
                state_d           = StNext;
                if (!primed_q[idx_q]) begin
                    shadow_d[idx_q] = lanes[idx_q];
                    primed_d[idx_q] = 1'b1;
                end else if (lanes[idx_q] != shadow_q[idx_q]) begin
                    push_req                       = 1'b1;
                    push_data[EVT_PORT_LSB +: 8]   = 8'(idx_q);
                    push_data[EVT_OLD_LSB +: 8]    = 8'(shadow_q[idx_q]);
                    push_data[EVT_NEW_LSB +: 8]    = 8'(lanes[idx_q]);
                    shadow_d[idx_q]                = lanes[idx_q];
                end
            end
            StNext: begin
                if (idx_q == IDX_W'(NUM_PORTS - 1)) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StSel;
                end
            end
            default: state_d = StIdle;
        endcase
        // Disabling aborts the scan on the edge that commits the write
        if (!en_d) begin
            state_d = StIdle;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            div_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            mask_q   <= '1;
            ovf_q    <= 1'b0;
            primed_q <= '0;
            shadow_q <= '{default: '0};
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            mask_q   <= mask_d;
            ovf_q    <= ovf_d;
            primed_q <= primed_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_en_q & (!fifo_empty | ovf_q);
        end
    end

endmodule

// File: tb/tb_pio_poll_scheduler.sv
// Directed self-checking bench for pio_poll_scheduler.
module tb_pio_poll_scheduler;

    localparam int unsigned NP  = 4;
    localparam int unsigned DIV = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mst_address;
    logic [NP-1:0] mst_select;
    logic [NP*32-1:0] mst_readdata = '0;
    logic [1:0]    s_address = '0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [31:0]   s_writedata = '0;
    logic [31:0]   s_readdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    pio_poll_scheduler #(
        .NUM_PORTS  (NP),
        .PORT_W     (4),
        .FIFO_DEPTH (8),
        .POLL_DIV   (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mst_address  (mst_address),
        .mst_select   (mst_select),
        .mst_readdata (mst_readdata),
        .s_address    (s_address),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        s_address = a; s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        check(tag, s_readdata, exp);
    endtask

    task automatic set_lane(input int p, input logic [3:0] v);
        mst_readdata[32*p +: 32] = 32'(v);
    endtask

    // Returns at the negedge where a port is first seen selected (its WAIT cycle)
    task automatic wait_sel(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 3 * DIV; n++) begin
            @(negedge clk);
            if (mst_select != '0) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_scan(input string tag);
        wait_sel(tag);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int n;
        bit seen;
        for (int p = 0; p < NP; p++) set_lane(p, 4'h3);
        repeat (3) @(negedge clk);
        check("rst_select", 32'(mst_select), 32'h0);
        check("rst_address", 32'(mst_address), 32'h0);
        check("rst_rdata", s_readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        read_check("rst_status", 2'd0, 32'h0000_0001);
        read_check("rst_mask", 2'd3, 32'h0000_000F);
        read_check("rst_ctrl", 2'd2, 32'h0000_0000);

        // 1: priming scan produces no events
        csr_write(2'd2, 32'h1);
        wait_scan("t1_scan1");
        read_check("t1_status_prime", 2'd0, 32'h0000_0001);
        wait_scan("t1_scan2");
        read_check("t1_status_stable", 2'd0, 32'h0000_0001);

        // 2: single change on port 2
        set_lane(2, 4'h9);
        wait_scan("t2_scan");
        read_check("t2_status_one", 2'd0, 32'h0000_0100);
        read_check("t2_event", 2'd1, 32'h8002_0309);
        read_check("t2_status_empty", 2'd0, 32'h0000_0001);
        read_check("t2_event_empty", 2'd1, 32'h0000_0000);

        // 3: nine toggles of port 0 overflow the 8-deep FIFO
        csr_write(2'd2, 32'h3);
        for (int k = 0; k < 9; k++) begin
            set_lane(0, (k % 2 == 0) ? 4'h4 : 4'h3);
            wait_scan("t3_scan");
        end
        read_check("t3_status_full_ovf", 2'd0, 32'h0000_0806);
        check("t3_irq", 32'(irq), 32'h1);
        csr_write(2'd2, 32'h7);
        read_check("t3_status_ovf_clr", 2'd0, 32'h0000_0802);
        check("t3_irq_still", 32'(irq), 32'h1);
        read_check("t3_ctrl_selfclr", 2'd2, 32'h0000_0003);

        // 5: push while full coincides with a pop of the oldest entry
        set_lane(0, 4'h3);
        wait_sel("t5_sel");
        @(negedge clk);
        check("t5_cmp_select", 32'(mst_select), 32'h1);
        s_address = 2'd1; s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        check("t5_pop_oldest", s_readdata, 32'h8000_0304);
        repeat (16) @(negedge clk);
        read_check("t5_status", 2'd0, 32'h0000_0802);
        read_check("t5_next_head", 2'd1, 32'h8000_0403);
        for (int k = 0; k < 6; k++) read_check("t5_drain", 2'd1, (k % 2 == 0) ? 32'h8000_0304 : 32'h8000_0403);
        read_check("t5_last_pushed", 2'd1, 32'h8000_0403);
        read_check("t5_status_empty", 2'd0, 32'h0000_0001);
        check("t5_irq_clear", 32'(irq), 32'h0);

        // 4: masked ports 0 and 2 are skipped
        csr_write(2'd2, 32'h0);
        csr_write(2'd3, 32'hA);
        csr_write(2'd2, 32'h3);
        set_lane(0, 4'h5);
        set_lane(2, 4'h7);
        set_lane(1, 4'h6);
        wait_sel("t4_sel");
        check("t4_first_select", 32'(mst_select), 32'h2);
        n = 0;
        while (mst_select != 4'b1000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_gap_cycles", 32'(n), 32'd6);
        repeat (16) @(negedge clk);
        read_check("t4_status", 2'd0, 32'h0000_0100);
        read_check("t4_event", 2'd1, 32'h8001_0306);
        read_check("t4_status_empty", 2'd0, 32'h0000_0001);

        // 6a: disable during WAIT aborts the scan
        wait_sel("t6_sel");
        s_address = 2'd2; s_writedata = 32'h2; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
        check("t6_abort_select", 32'(mst_select), 32'h0);
        seen = 1'b0;
        repeat (2 * DIV) begin
            @(negedge clk);
            if (mst_select != '0) seen = 1'b1;
        end
        check("t6_idle_hold", 32'(seen), 32'h0);
        read_check("t6_ctrl", 2'd2, 32'h0000_0002);

        // 6b: reset mid-scan restores everything and re-primes
        csr_write(2'd3, 32'h5);
        csr_write(2'd2, 32'h1);
        wait_sel("t6_sel2");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_select", 32'(mst_select), 32'h0);
        check("t6_rst_rdata", s_readdata, 32'h0);
        check("t6_rst_irq", 32'(irq), 32'h0);
        read_check("t6_rst_mask", 2'd3, 32'h0000_000F);
        read_check("t6_rst_ctrl", 2'd2, 32'h0000_0000);
        set_lane(0, 4'hA);
        csr_write(2'd2, 32'h1);
        wait_scan("t6_reprime_scan");
        read_check("t6_reprime_status", 2'd0, 32'h0000_0001);
        set_lane(0, 4'hB);
        wait_scan("t6_change_scan");
        read_check("t6_event", 2'd1, 32'h8000_0A0B);
        read_check("t6_status_final", 2'd0, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
